// File: rtl/cam_store.sv
// cam_store: storage and write side of the CAM.
// Holds DEPTH words with per-entry written flags, accepts indexed writes and
// deletes, keeps a live-entry counter, and runs a one-cycle content search
// that returns the lowest matching written entry.
// Ports:
//   clk, rst                      clock, async active-high reset
//   write_en_i/index/data         store a word and mark the entry written
//   delete_en_i/index             clear an entry's written flag
//   search_en_i/search_data_i     start a search for the given key
//   data_o, written_o             flattened storage and written flags
//   count_o, full_o               number of written entries, all written
//   search_valid_o/found/index    search result, valid for one cycle
module cam_store #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH,
  parameter int unsigned SIZE       = DATA_WIDTH * DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] write_index_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic                  delete_en_i,
  input  logic [ADDR_WIDTH-1:0] delete_index_i,
  input  logic                  search_en_i,
  input  logic [DATA_WIDTH-1:0] search_data_i,
  output logic [SIZE-1:0]       data_o,
  output logic [DEPTH-1:0]      written_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  search_valid_o,
  output logic                  search_found_o,
  output logic [ADDR_WIDTH-1:0] search_index_o
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  typedef enum logic {S_IDLE, S_RESULT} state_t;

  state_t                state_q, state_d;
  logic [SIZE-1:0]       data_d;
  logic [DEPTH-1:0]      written_d;
  logic [CNT_W-1:0]      count_d;
  logic                  found_d;
  logic [ADDR_WIDTH-1:0] index_d;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] hit_idx;
  logic                  wr_new;
  logic                  del_eff;

  // Next storage contents; on a same-index write/delete the write wins
  always_comb begin
    data_d    = data_o;
    written_d = written_o;
    count_d   = count_o;
    wr_new    = write_en_i && !written_o[write_index_i];
    del_eff   = delete_en_i && written_o[delete_index_i] &&
                !(write_en_i && (write_index_i == delete_index_i));
    if (delete_en_i) written_d[delete_index_i] = 1'b0;
    if (write_en_i) begin
      written_d[write_index_i] = 1'b1;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (write_index_i == ADDR_WIDTH'(i))
          data_d[i*DATA_WIDTH +: DATA_WIDTH] = write_data_i;
      end
    end
    // Counter moves only on flag transitions, so it stays within 0..DEPTH
    case ({wr_new, del_eff})
      2'b10:   count_d = count_o + CNT_W'(1);
      2'b01:   count_d = count_o - CNT_W'(1);
      default: count_d = count_o;
    endcase
  end

  // Priority match against pre-edge contents: the first (lowest) hit is kept
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!hit && written_o[i] &&
          (data_o[i*DATA_WIDTH +: DATA_WIDTH] == search_data_i)) begin
        hit     = 1'b1;
        hit_idx = ADDR_WIDTH'(i);
      end
    end
  end

  // Search FSM next state; result registers hold when no search starts
  always_comb begin
    state_d = S_IDLE;
    found_d = search_found_o;
    index_d = search_index_o;
    case (state_q)
      S_IDLE:   if (search_en_i) state_d = S_RESULT;
      S_RESULT: if (search_en_i) state_d = S_RESULT;
      default:  state_d = S_IDLE;
    endcase
    if (search_en_i) begin
      found_d = hit;
      index_d = hit_idx;
    end
  end

  // State and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      data_o         <= '0;
      written_o      <= '0;
      count_o        <= '0;
      search_found_o <= 1'b0;
      search_index_o <= '0;
    end else begin
      state_q        <= state_d;
      data_o         <= data_d;
      written_o      <= written_d;
      count_o        <= count_d;
      search_found_o <= found_d;
      search_index_o <= index_d;
    end
  end

  assign search_valid_o = (state_q == S_RESULT);
  assign full_o         = (count_o == CNT_W'(DEPTH));

endmodule
